sprite_renderer: RTL and testbench

Downstream consumer of the sprite pixel banks. Takes the raster coordinate stream from the VGA timing logic, looks up which sprite occupies each 16×16 tile of the screen in an internal tile map, and drives the sprite bank's `x`/`y`/`index` lookup. It samples the returned RGBA, alpha-tests it against a programmable background colour, and emits RGB888 to the video DAC path. It shares the 32-bit `control` command bus with the sprite banks and decodes its own opcodes.

---
 rtl/sprite_renderer.sv | 199 +++++++++++++++++++
 tb/tb_sprite_renderer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// Tile-mapped sprite compositor: raster coordinates -> tile-map lookup -> bank RGBA -> alpha-tested RGB888.
// Optional tile-boundary debug overlay enabled by defining SPRITE_RENDERER_GRID_EN.
module sprite_renderer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] control,
  input  logic        pix_valid,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [31:0] sprite_rgba,
  output logic [3:0]  sprite_x,
  output logic [3:0]  sprite_y,
  output logic [7:0]  sprite_index,
  output logic        out_valid,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        clear_busy
);

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned COLS      = 40;
  localparam int unsigned ROWS      = 30;
  localparam int unsigned TILES     = COLS * ROWS;
  localparam logic [10:0] LAST_TILE = 11'(TILES - 1);

  localparam logic [3:0] OP_TILE = 4'h2;
  localparam logic [3:0] OP_BG   = 4'h3;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  // row*40 + col without a multiplier
  function automatic logic [10:0] tile_addr(input logic [5:0] col, input logic [4:0] row);
    return ({6'd0, row} << 5) + ({6'd0, row} << 3) + {5'd0, col};
  endfunction

  state_e      state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == LAST_TILE) begin
        state_d   = ST_RUN;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + 11'd1;
      end
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);

  logic [3:0]  opcode;
  logic [5:0]  cmd_col;
  logic [4:0]  cmd_row;
  logic        tile_cmd_ok;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;

  assign opcode      = control[31:28];
  assign cmd_col     = control[19:14];
  assign cmd_row     = control[13:9];
  assign tile_cmd_ok = (opcode == OP_TILE) && (cmd_col < 6'(COLS)) && (cmd_row < 5'(ROWS));

  // The clear sweep owns the write port; command writes only land in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_cnt_q;
    wr_data = '0;
    if (state_q == ST_CLEAR) begin
      wr_en = 1'b1;
    end else if (tile_cmd_ok) begin
      wr_en   = 1'b1;
      wr_addr = tile_addr(cmd_col, cmd_row);
      wr_data = control[27:20];
    end
  end

  logic        s0_in_range;
  logic [10:0] rd_addr;
  logic [7:0]  tile_mem [TILES];
  logic [7:0]  tile_rd_q;

  assign s0_in_range = (draw_x < 10'(H_ACTIVE)) && (draw_y < 10'(V_ACTIVE));
  assign rd_addr     = s0_in_range ? tile_addr(draw_x[9:4], draw_y[8:4]) : 11'd0;

  // NOTE: the tile map carries no reset; the CLEAR sweep zeroes it, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) tile_mem[wr_addr] <= wr_data;
    tile_rd_q <= tile_mem[rd_addr];
  end

  logic       s1_valid_q, s1_in_range_q;
  logic [3:0] s1_x_q, s1_y_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_in_range_q <= 1'b0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
    end else begin
      s1_valid_q    <= pix_valid;
      s1_in_range_q <= s0_in_range;
      s1_x_q        <= draw_x[3:0];
      s1_y_q        <= draw_y[3:0];
    end
  end

  assign sprite_x     = s1_x_q;
  assign sprite_y     = s1_y_q;
  assign sprite_index = (s1_in_range_q && state_q == ST_RUN) ? tile_rd_q : 8'd0;

  logic        s2_valid_q, s2_in_range_q, s2_empty_q, s2_opaque_q;
  logic [23:0] s2_rgb_q;
  logic        unused_alpha_bits;

  assign unused_alpha_bits = ^sprite_rgba[6:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q    <= 1'b0;
      s2_in_range_q <= 1'b0;
      s2_empty_q    <= 1'b1;
      s2_opaque_q   <= 1'b0;
      s2_rgb_q      <= '0;
    end else begin
      s2_valid_q    <= s1_valid_q;
      s2_in_range_q <= s1_in_range_q;
      s2_empty_q    <= (sprite_index == 8'd0);
      s2_opaque_q   <= sprite_rgba[7];
      s2_rgb_q      <= sprite_rgba[31:8];
    end
  end

`ifdef SPRITE_RENDERER_GRID_EN
  logic s2_grid_q;

  always_ff @(posedge clk) begin
    if (reset) s2_grid_q <= 1'b0;
    else       s2_grid_q <= (s1_x_q == 4'd0) || (s1_y_q == 4'd0);
  end
`endif

  logic [23:0] bg_q;

  always_ff @(posedge clk) begin
    if (reset)                 bg_q <= '0;
    else if (opcode == OP_BG)  bg_q <= control[23:0];
  end

  logic [23:0] px_d;

  always_comb begin
    px_d = bg_q;
    if (!s2_in_range_q) begin
      px_d = '0;
`ifdef SPRITE_RENDERER_GRID_EN
    end else if (s2_grid_q) begin
      px_d = 24'h404040;
`endif
    end else if (!s2_empty_q && s2_opaque_q) begin
      px_d = s2_rgb_q;
    end
  end

  logic        out_valid_q;
  logic [23:0] rgb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) rgb_q <= px_d;
    end
  end

  assign out_valid = out_valid_q;
  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: driver queues expected pixels, a negedge monitor pops and compares.
module tb_sprite_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] control = '0;
  logic        pix_valid = 1'b0;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;
  logic [31:0] sprite_rgba;
  logic [3:0]  sprite_x, sprite_y;
  logic [7:0]  sprite_index;
  logic        out_valid;
  logic [7:0]  red, green, blue;
  logic        clear_busy;

  logic [31:0] bank_word = 32'hFF8040FF;

  // Bank model: empty index returns an opaque junk word so a missed empty-tile test shows up.
  assign sprite_rgba = (sprite_index == 8'd0) ? 32'hDEADBEEF : bank_word;

  sprite_renderer dut (
    .clk          (clk),
    .reset        (reset),
    .control      (control),
    .pix_valid    (pix_valid),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .sprite_rgba  (sprite_rgba),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_index (sprite_index),
    .out_valid    (out_valid),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .clear_busy   (clear_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] rgb;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] grid(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb);
`ifdef SPRITE_RENDERER_GRID_EN
    if (x < 10'd640 && y < 10'd480 && (x[3:0] == 4'd0 || y[3:0] == 4'd0)) return 24'h404040;
`endif
    return rgb;
  endfunction

  function automatic logic [31:0] tile_cmd(input logic [7:0] idx, input logic [5:0] col, input logic [4:0] row);
    return {4'h2, idx, col, row, 9'd0};
  endfunction

  function automatic logic [31:0] bg_cmd(input logic [23:0] rgb);
    return {4'h3, 4'h0, rgb};
  endfunction

  // Call just after a rising edge: the pixel is presented in the current cycle.
  task automatic push_exp(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb);
    exp_t e;
    e.rgb = grid(x, y, rgb);
    e.due = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb, input bit expect_out);
    @(posedge clk); #1;
    pix_valid = 1'b1;
    draw_x    = x;
    draw_y    = y;
    if (expect_out) push_exp(x, y, rgb);
  endtask

  task automatic send_probe(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb,
                            input logic [7:0] idx, input logic [3:0] sx, input logic [3:0] sy);
    drive_pixel(x, y, rgb, 1'b1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    check({tag, " index"}, {24'd0, sprite_index}, {24'd0, idx});
    check({tag, " sprite_x"}, {28'd0, sprite_x}, {28'd0, sx});
    check({tag, " sprite_y"}, {28'd0, sprite_y}, {28'd0, sy});
  endtask

  task automatic cmd(input logic [31:0] w);
    @(posedge clk); #1;
    control = w;
    @(posedge clk); #1;
    control = '0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      pix_valid = 1'b0;
      n++;
    end
    check({tag, " drain"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pixel rgb", {8'd0, red, green, blue}, {8'd0, mon_e.rgb});
        check("pixel latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset rgb", {8'd0, red, green, blue}, 32'd0);
    check("reset sprite_x", {28'd0, sprite_x}, 32'd0);
    check("reset sprite_y", {28'd0, sprite_y}, 32'd0);
    check("reset sprite_index", {24'd0, sprite_index}, 32'd0);
    check("reset clear_busy", {31'd0, clear_busy}, 32'd1);

    // Initial clear with (0,0) streaming every cycle
    @(posedge clk); #1;
    reset = 1'b0;
    busy  = 0;
    for (int i = 0; i < 1500; i++) begin
      pix_valid = 1'b1;
      draw_x    = 10'd0;
      draw_y    = 10'd0;
      push_exp(10'd0, 10'd0, 24'h000000);
      @(negedge clk);
      if (!clear_busy) break;
      busy++;
      @(posedge clk); #1;
    end
    check("clear cycles", busy, 1200);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    drain("clear stream");

    // Sprite hit, transparent sprite, empty tile
    cmd(bg_cmd(24'h123456));
    cmd(tile_cmd(8'd5, 6'd2, 5'd1));
    bank_word = 32'hFF8040FF;
    send_probe("opaque", 10'd35, 10'd20, 24'hFF8040, 8'd5, 4'd3, 4'd4);
    drain("opaque");
    bank_word = 32'hFF804000;
    send_probe("alpha0", 10'd35, 10'd20, 24'h123456, 8'd5, 4'd3, 4'd4);
    drain("alpha0");
    bank_word = 32'hFF8040FF;
    send_probe("empty tile", 10'd100, 10'd100, 24'h123456, 8'd0, 4'd4, 4'd4);
    drain("empty tile");

    // Back-to-back pixels including both out-of-range edges
    drive_pixel(10'd35, 10'd20, 24'hFF8040, 1'b1);
    drive_pixel(10'd640, 10'd0, 24'h000000, 1'b1);
    drive_pixel(10'd0, 10'd480, 24'h000000, 1'b1);
    drive_pixel(10'd36, 10'd21, 24'hFF8040, 1'b1);
    drive_pixel(10'd639, 10'd479, 24'h123456, 1'b1);
    drain("back-to-back");

    // Out-of-range tile commands must leave the map untouched
    cmd(tile_cmd(8'd9, 6'd40, 5'd0));
    cmd(tile_cmd(8'd9, 6'd63, 5'd0));
    send_probe("col40 edge", 10'd639, 10'd0, 24'h123456, 8'd0, 4'd15, 4'd0);
    send_probe("col40 alias", 10'd0, 10'd16, 24'h123456, 8'd0, 4'd0, 4'd0);
    send_probe("col63 alias", 10'd368, 10'd16, 24'h123456, 8'd0, 4'd0, 4'd0);
    drain("bad col");

    // Last tile and out-of-range masking with tile 0 populated
    cmd(tile_cmd(8'd7, 6'd39, 5'd29));
    cmd(tile_cmd(8'd4, 6'd0, 5'd0));
    send_probe("last tile", 10'd639, 10'd479, 24'hFF8040, 8'd7, 4'd15, 4'd15);
    send_probe("oor x", 10'd640, 10'd0, 24'h000000, 8'd0, 4'd0, 4'd0);
    send_probe("oor y", 10'd0, 10'd480, 24'h000000, 8'd0, 4'd0, 4'd0);
    drain("edges");

    // Write and lookup of the same tile in the same cycle
    @(posedge clk); #1;
    control   = tile_cmd(8'd3, 6'd10, 5'd10);
    pix_valid = 1'b1;
    draw_x    = 10'd160;
    draw_y    = 10'd160;
    push_exp(10'd160, 10'd160, 24'h123456);
    @(posedge clk); #1;
    control = '0;
    push_exp(10'd160, 10'd160, 24'hFF8040);
    @(negedge clk);
    check("same-cycle old index", {24'd0, sprite_index}, 32'd0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    check("next-cycle new index", {24'd0, sprite_index}, 32'd3);
    drain("same-cycle");

    // Sprite-bank opcode is not ours
    cmd({4'h1, 8'd5, 6'd6, 5'd6, 9'd0});
    send_probe("opcode1 ignored", 10'd100, 10'd100, 24'h123456, 8'd0, 4'd4, 4'd4);
    drain("opcode1");

    // Background write while a pixel sits in S3
    @(posedge clk); #1;
    pix_valid = 1'b1;
    draw_x    = 10'd100;
    draw_y    = 10'd100;
    push_exp(10'd100, 10'd100, 24'h123456);
    @(posedge clk); #1;
    push_exp(10'd100, 10'd100, 24'hABCDEF);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    control   = bg_cmd(24'hABCDEF);
    @(posedge clk); #1;
    control = '0;
    drain("bg timing");

    // In-flight pixel discarded by reset, then reset again mid-clear
    drive_pixel(10'd35, 10'd20, 24'h000000, 1'b0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid-clear busy", {31'd0, clear_busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    busy  = 0;
    for (int i = 0; i < 1500; i++) begin
      control = (i == 5) ? tile_cmd(8'd5, 6'd6, 5'd6) : 32'd0;
      @(negedge clk);
      if (!clear_busy) break;
      busy++;
      @(posedge clk); #1;
    end
    control = '0;
    check("clear after mid reset", busy, 1200);

    send_probe("cleared tile", 10'd35, 10'd20, 24'h000000, 8'd0, 4'd3, 4'd4);
    send_probe("write during clear", 10'd100, 10'd100, 24'h000000, 8'd0, 4'd4, 4'd4);
    send_probe("cleared last tile", 10'd639, 10'd479, 24'h000000, 8'd0, 4'd15, 4'd15);
    drain("after reclear");

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
